// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage next-PC sequencer:
// FSM state encoding, next-PC source select codes and PC width.
package fetch_ctrl_pkg;

   // Width of the program counter register that this block feeds.
   localparam int PC_W = 9;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2,
      ST_STEP = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      SEL_VEC  = 3'd0,
      SEL_SEQ  = 3'd1,
      SEL_JMP  = 3'd2,
      SEL_BR   = 3'd3,
      SEL_HOLD = 3'd4
   } npc_sel_t;

endpackage

// File: rtl/fetch_npc_mux.sv
// Next-PC source multiplexer, purely combinational.
// Ports: sel (source code), pc_f, jump_target, branch_target in;
//        pc_next (selected address), pc_inc (pc_f + 1, wrapping) out.
module fetch_npc_mux
   import fetch_ctrl_pkg::*;
#(
   parameter int              PC_W         = fetch_ctrl_pkg::PC_W,
   parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
   input  npc_sel_t        sel,
   input  logic [PC_W-1:0] pc_f,
   input  logic [PC_W-1:0] jump_target,
   input  logic [PC_W-1:0] branch_target,
   output logic [PC_W-1:0] pc_next,
   output logic [PC_W-1:0] pc_inc
);

   // Natural overflow gives the required wrap from the top address to 0.
   assign pc_inc = pc_f + PC_W'(1);

   // Hold returns the current PC; the top decides what it presents.
   always_comb begin
      pc_next = pc_f;
      unique case (sel)
         SEL_VEC:  pc_next = RESET_VECTOR;
         SEL_SEQ:  pc_next = pc_inc;
         SEL_JMP:  pc_next = jump_target;
         SEL_BR:   pc_next = branch_target;
         SEL_HOLD: pc_next = pc_f;
         default:  pc_next = pc_f;
      endcase
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Next-PC sequencer: arbitrates sequential fetch, jump, branch, stall,
// halt and debug single-step; drives the PC register and IF/ID flush.
// Ports: clk, reset (sync, active-high); pc_f, stall_d, jump_d,
//        jump_target_d, branch_taken_d, branch_target_d, halt_d, run,
//        step in; pc_next, pc_en, flush_d, halted, fetch_count out.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int              PC_W         = fetch_ctrl_pkg::PC_W,
   parameter logic [PC_W-1:0] RESET_VECTOR = '0,
   parameter int              CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PC_W-1:0]  pc_f,
   input  logic             stall_d,
   input  logic             jump_d,
   input  logic [PC_W-1:0]  jump_target_d,
   input  logic             branch_taken_d,
   input  logic [PC_W-1:0]  branch_target_d,
   input  logic             halt_d,
   input  logic             run,
   input  logic             step,
   output logic [PC_W-1:0]  pc_next,
   output logic             pc_en,
   output logic             flush_d,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_count
);

   state_t   state;
   state_t   state_nxt;
   npc_sel_t sel;

   logic [PC_W-1:0] pc_sel;
   logic [PC_W-1:0] pc_inc;

   // Priority-resolved decode events: exactly one is high.
   logic go_stall;
   logic go_halt;
   logic go_jmp;
   logic go_br;
   logic go_seq;

   assign go_stall = stall_d;
   assign go_halt  = !stall_d && halt_d;
   assign go_jmp   = !stall_d && !halt_d && jump_d;
   assign go_br    = !stall_d && !halt_d && !jump_d
                     && branch_taken_d;
   assign go_seq   = !stall_d && !halt_d && !jump_d
                     && !branch_taken_d;

   fetch_npc_mux #(
      .PC_W         (PC_W),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_npc_mux (
      .sel           (sel),
      .pc_f          (pc_f),
      .jump_target   (jump_target_d),
      .branch_target (branch_target_d),
      .pc_next       (pc_sel),
      .pc_inc        (pc_inc)
   );

   // With the load disabled the value is a don't-care; present pc_f+1
   // so the PC data input stays stable while fetch is frozen.
   assign pc_next = (sel == SEL_HOLD) ? pc_inc : pc_sel;

   always_comb begin
      sel       = SEL_HOLD;
      pc_en     = 1'b0;
      flush_d   = 1'b0;
      halted    = 1'b0;
      state_nxt = state;
      if (reset) begin
         sel       = SEL_VEC;
         pc_en     = 1'b1;
         flush_d   = 1'b1;
         state_nxt = ST_INIT;
      end else begin
         unique case (state)
            ST_INIT: begin
               sel       = SEL_VEC;
               pc_en     = 1'b1;
               flush_d   = 1'b1;
               state_nxt = ST_RUN;
            end
            ST_RUN, ST_STEP: begin
               // STEP shares the RUN datapath so it advances at most once.
               unique case (1'b1)
                  go_stall: begin
                     sel = SEL_HOLD;
                  end
                  go_halt: begin
                     sel     = SEL_HOLD;
                     flush_d = 1'b1;
                  end
                  go_jmp: begin
                     sel     = SEL_JMP;
                     pc_en   = 1'b1;
                     flush_d = 1'b1;
                  end
                  go_br: begin
                     sel     = SEL_BR;
                     pc_en   = 1'b1;
                     flush_d = 1'b1;
                  end
                  go_seq: begin
                     sel   = SEL_SEQ;
                     pc_en = 1'b1;
                  end
                  default: begin
                     sel = SEL_HOLD;
                  end
               endcase
               if (state == ST_STEP || go_halt) begin
                  state_nxt = ST_HALT;
               end
            end
            ST_HALT: begin
               halted = 1'b1;
               if (run) begin
                  state_nxt = ST_RUN;
               end else if (step) begin
                  state_nxt = ST_STEP;
               end
            end
            default: begin
               state_nxt = ST_INIT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_INIT;
         fetch_count <= '0;
      end else begin
         state <= state_nxt;
         if (pc_en) begin
            fetch_count <= fetch_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Next-PC sequencer for the fetch stage. Drives the load enable and next-address input of the 9-bit program counter register. Arbitrates between sequential fetch, jump, taken branch and hazard stall, and implements halt and debug single-step. Sits between the decode-stage hazard/branch logic and the PC register; also drives the IF/ID flush.

Parameters:
PC_W, 9, program counter width in bits
RESET_VECTOR, 0, address loaded into the PC on reset
CNT_W, 16, width of the fetch counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
pc_f  in  PC_W  current PC register output
stall_d  in  1  load-use stall request from the hazard unit
jump_d  in  1  jump decoded in the decode stage
jump_target_d  in  PC_W  jump destination
branch_taken_d  in  1  branch resolved taken in the decode stage
branch_target_d  in  PC_W  branch destination
halt_d  in  1  halt opcode present in the decode stage
run  in  1  debug resume pulse, one cycle
step  in  1  debug single-step pulse, one cycle
pc_next  out  PC_W  next-PC value to the PC register data input
pc_en  out  1  PC register load enable
flush_d  out  1  clear the IF/ID pipeline register
halted  out  1  high while in the HALT state
fetch_count  out  CNT_W  count of PC loads since reset

Behaviour:
- State register (2 bits): INIT, RUN, HALT, STEP. The state register is the only sequential state besides fetch_count.
- Outputs are combinational from state and inputs. fetch_count is registered.
- While reset=1:
  - pc_en=1, pc_next=RESET_VECTOR, flush_d=1, halted=0.
  - On the next edge: state becomes INIT and fetch_count becomes 0.
- INIT (one cycle):
  - pc_en=1, pc_next=RESET_VECTOR, flush_d=1.
  - Next state is RUN. This re-loads the vector so the PC is valid after reset deassertion.
- RUN priority, highest first:
  - stall_d=1: pc_en=0, flush_d=0. Jump, branch and halt are all ignored this cycle; the hazard unit re-presents them.
  - halt_d=1: pc_en=0, flush_d=1, next state HALT.
  - jump_d=1: pc_next=jump_target_d, pc_en=1, flush_d=1.
  - branch_taken_d=1: pc_next=branch_target_d, pc_en=1, flush_d=1.
  - Otherwise: pc_next=pc_f+1 modulo 2^PC_W (511 wraps to 0), pc_en=1, flush_d=0.
  - If jump_d and branch_taken_d are both high, the jump wins.
- HALT:
  - pc_en=0, flush_d=0, halted=1.
  - pc_next=pc_f+1, a don't-care value held stable.
  - run=1: next state RUN. The first PC load happens in the following cycle.
  - step=1 with run=0: next state STEP.
  - run and step both high: run wins.
- STEP (one cycle):
  - Uses the same datapath priority as RUN, so exactly one fetch-stage advance occurs, or none if stall_d=1.
  - Next state is HALT, unless halt_d is decoded, which also goes to HALT.
  - halted=0 during STEP.
- fetch_count:
  - Increments on every edge where pc_en=1 and reset=0. INIT counts.
  - Wraps at 2^CNT_W. It is not incremented in reset cycles.
- Reset asserted in any state, including mid-STEP or HALT, forces the reset outputs that cycle. The state machine restarts at INIT.
- Unreachable state encoding: next state is INIT.
- No input is registered. Total latency from redirect input to pc_next is 0 cycles; the PC register captures it on the next edge.

Decomposition:
- Shared package:
  - State encoding constants: ST_INIT=0, ST_RUN=1, ST_HALT=2, ST_STEP=3.
  - Next-PC source select encoding: SEL_VEC, SEL_SEQ, SEL_JMP, SEL_BR, SEL_HOLD.
  - PC_W, shared with the PC register.
- One sub-module: fetch_npc_mux. It is combinational: inputs are the select code, pc_f and both targets; outputs are pc_next and the incremented PC.
- The FSM and counter stay in fetch_ctrl.

Test Plan:
- Reset release: hold reset 3 cycles, then release -> pc_en=1 and pc_next=0 during reset and INIT; RUN next; pc_next=pc_f+1 thereafter; fetch_count=1 after INIT.
- Wrap and count: pc_f=511 in RUN, no events -> pc_next=0, pc_en=1, flush_d=0; fetch_count increments by 1 per cycle.
- Redirect priority:
  - pc_f=20, jump_d=1 with jump_target_d=100, and branch_taken_d=1 with branch_target_d=200 -> pc_next=100, flush_d=1.
  - Same cycle with stall_d=1 -> pc_en=0, flush_d=0.
- Halt then step:
  - halt_d=1 in RUN -> pc_en=0, flush_d=1, halted=1 next cycle.
  - step pulse -> exactly one cycle with pc_en=1, then HALT again.
  - fetch_count advances by exactly 1.
- Resume: in HALT, assert run and step together -> RUN next cycle, sequential fetch resumes, no STEP state visited.
- Reset mid-STEP: assert reset during STEP -> that cycle pc_next=0, pc_en=1, halted=0; INIT follows; fetch_count=0.
